// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, bus widths and the responder FSM state type.
package ahb3lite_pkg;

    localparam int unsigned HTRANS_SIZE = 2;
    localparam int unsigned HSIZE_SIZE  = 3;
    localparam int unsigned HBURST_SIZE = 3;
    localparam int unsigned HPROT_SIZE  = 4;

    localparam logic [HTRANS_SIZE-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_SIZE-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [HTRANS_SIZE-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HTRANS_SIZE-1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [HSIZE_SIZE-1:0] HSIZE_B8    = 3'b000;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_B16   = 3'b001;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_B32   = 3'b010;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_B64   = 3'b011;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_B128  = 3'b100;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_B256  = 3'b101;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_B512  = 3'b110;
    localparam logic [HSIZE_SIZE-1:0] HSIZE_B1024 = 3'b111;

    localparam logic [HBURST_SIZE-1:0] HBURST_SINGLE = 3'b000;
    localparam logic [HBURST_SIZE-1:0] HBURST_INCR   = 3'b001;
    localparam logic [HBURST_SIZE-1:0] HBURST_WRAP4  = 3'b010;
    localparam logic [HBURST_SIZE-1:0] HBURST_INCR4  = 3'b011;
    localparam logic [HBURST_SIZE-1:0] HBURST_WRAP8  = 3'b100;
    localparam logic [HBURST_SIZE-1:0] HBURST_INCR8  = 3'b101;
    localparam logic [HBURST_SIZE-1:0] HBURST_WRAP16 = 3'b110;
    localparam logic [HBURST_SIZE-1:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        OKAY,
        ERR1,
        ERR2
    } ahb_resp_state_t;

endpackage

// File: rtl/ahb3lite_resp_lanes.sv
// Byte-enable decoder: selects the little-endian byte lanes touched by a transfer.
module ahb3lite_resp_lanes
    import ahb3lite_pkg::*;
#(
    parameter int unsigned HDATA_SIZE = 32
) (
    input  logic [HSIZE_SIZE-1:0]           hsize,
    input  logic [$clog2(HDATA_SIZE/8)-1:0] haddr_lo,
    output logic [HDATA_SIZE/8-1:0]         be_c
);

    localparam int unsigned NB = HDATA_SIZE / 8;
    localparam int unsigned LB = $clog2(NB);

    // A lane is enabled when it sits in the same size-aligned chunk as the address.
    always_comb begin
        be_c = '0;
        for (int i = 0; i < NB; i++) begin
            be_c[i] = ((LB'(i) >> hsize) == (haddr_lo >> hsize));
        end
    end

endmodule

// File: rtl/ahb3lite_resp_mem.sv
// AHB3-Lite memory responder with per-transfer wait states and an error window.
module ahb3lite_resp_mem
    import ahb3lite_pkg::*;
#(
    parameter int unsigned HADDR_SIZE = 20,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned ERR_BASE   = 32'h000F_0000,
    parameter int unsigned ERR_SIZE   = 32'h0000_0100
) (
    input  logic                   HRESETn,
    input  logic                   HCLK,
    input  logic                   HSEL,
    input  logic [HTRANS_SIZE-1:0] HTRANS,
    input  logic [HSIZE_SIZE-1:0]  HSIZE,
    input  logic [HBURST_SIZE-1:0] HBURST,
    input  logic [HPROT_SIZE-1:0]  HPROT,
    input  logic                   HWRITE,
    input  logic                   HMASTLOCK,
    input  logic [HADDR_SIZE-1:0]  HADDR,
    input  logic [HDATA_SIZE-1:0]  HWDATA,
    output logic [HDATA_SIZE-1:0]  HRDATA,
    output logic                   HREADYOUT,
    input  logic                   HREADY,
    output logic                   HRESP,
    input  logic [3:0]             wait_i
);

    localparam int unsigned NB = HDATA_SIZE / 8;
    localparam int unsigned LB = $clog2(NB);
    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam logic [63:0] SPAN   = 64'(MEM_DEPTH) * 64'(NB);
    localparam logic [63:0] ERR_LO = 64'(ERR_BASE);
    localparam logic [63:0] ERR_HI = 64'(ERR_BASE) + 64'(ERR_SIZE);

    ahb_resp_state_t        state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [LB-1:0]          lo_q, lo_d;
    logic [HSIZE_SIZE-1:0]  size_q, size_d;
    logic                   write_q, write_d;
    logic [HDATA_SIZE-1:0]  hrdata_q, hrdata_d;
    logic                   hreadyout_q, hreadyout_d;
    logic                   hresp_q, hresp_d;

    logic [HDATA_SIZE-1:0]  mem [MEM_DEPTH];

    logic [NB-1:0]          be_c;
    logic                   accept_c;
    logic                   err_c;
    logic                   commit_c;
    logic [63:0]            haddr_ext_c;
    logic [6:0]             lo_mask_c;
    logic [HDATA_SIZE-1:0]  rd_word_c;

    logic                   unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

    // Lane enables for the transfer currently in its data phase.
    ahb3lite_resp_lanes #(
        .HDATA_SIZE (HDATA_SIZE)
    ) u_lanes (
        .hsize    (size_q),
        .haddr_lo (lo_q),
        .be_c     (be_c)
    );

    // Address-phase qualification and error classification.
    always_comb begin
        accept_c    = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
        haddr_ext_c = 64'(HADDR);
        lo_mask_c   = 7'((8'd1 << HSIZE) - 8'd1);
        err_c       = (haddr_ext_c >= SPAN)
                    || ((ERR_SIZE != 32'd0) && (haddr_ext_c >= ERR_LO) && (haddr_ext_c < ERR_HI))
                    || (|(HADDR[6:0] & lo_mask_c))
                    || ((32'd8 << HSIZE) > HDATA_SIZE);
    end

    // Next state, transfer capture, read/forward path and registered response.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        lo_d     = lo_q;
        size_d   = size_q;
        write_d  = write_q;
        hrdata_d = hrdata_q;
        commit_c = (state_q == OKAY) && write_q;

        case (state_q)
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = OKAY;
                end
            end
            ERR1: begin
                state_d = ERR2;
            end
            default: begin
                if (accept_c) begin
                    idx_d   = HADDR[AW+LB-1:LB];
                    lo_d    = HADDR[LB-1:0];
                    size_d  = HSIZE;
                    write_d = HWRITE;
                    if (err_c) begin
                        state_d = ERR1;
                        cnt_d   = '0;
                    end else if (wait_i != 4'd0) begin
                        state_d = WAIT;
                        cnt_d   = wait_i;
                    end else begin
                        state_d = OKAY;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase

        // A read landing on the word being written this edge sees the new bytes.
        rd_word_c = mem[idx_d];
        if (commit_c && (idx_q == idx_d)) begin
            for (int b = 0; b < NB; b++) begin
                if (be_c[b]) begin
                    rd_word_c[8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
        end

        if ((state_d == OKAY) && !write_d) begin
            hrdata_d = rd_word_c;
        end

        hreadyout_d = !((state_d == WAIT) || (state_d == ERR1));
        hresp_d     = (state_d == ERR1) || (state_d == ERR2);
    end

    // Control and response registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            lo_q        <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
            size_q      <= size_d;
            write_q     <= write_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Storage: byte-lane write at the edge that completes a write data phase.
    always_ff @(posedge HCLK) begin
        if (commit_c) begin
            for (int b = 0; b < NB; b++) begin
                if (be_c[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb3lite_resp_mem.sv
// Directed bench for the AHB3-Lite memory responder.
module tb_ahb3lite_resp_mem;
    import ahb3lite_pkg::*;

    logic        HRESETn;
    logic        HCLK = 1'b0;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic        HMASTLOCK;
    logic [19:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HREADY;
    logic        HRESP;
    logic [3:0]  wait_i;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb3lite_resp_mem dut (
        .HRESETn   (HRESETn),
        .HCLK      (HCLK),
        .HSEL      (HSEL),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HWRITE    (HWRITE),
        .HMASTLOCK (HMASTLOCK),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .wait_i    (wait_i)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wt;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    int n_cmp;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        HSEL      = 1'b0;
        HTRANS    = HTRANS_IDLE;
        HADDR     = '0;
        HWRITE    = 1'b0;
        HSIZE     = HSIZE_B32;
        HBURST    = HBURST_SINGLE;
        HPROT     = 4'h3;
        HMASTLOCK = 1'b0;
        wait_i    = '0;
    endtask

    // Single non-pipelined transfer; call and return at posedge+1.
    task automatic do_xfer(input vec_t v, input string tag);
        int          cyc;
        logic        done;
        logic [31:0] rd;
        logic        err;
        HSEL   = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HADDR  = v.addr;
        HWRITE = v.wr;
        HSIZE  = v.size;
        wait_i = v.wt;
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = v.wdata;
        cyc  = 0;
        done = 1'b0;
        rd   = '0;
        err  = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge HCLK);
            cyc++;
            if (HREADYOUT) begin
                done = 1'b1;
                rd   = HRDATA;
                err  = HRESP;
            end
            @(posedge HCLK); #1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: HREADYOUT stuck low after %0d cycles, want high", tag, cyc);
        end else begin
            check({tag, " cycles"}, 32'(cyc), 32'(v.exp_cyc));
            check({tag, " hresp"}, 32'(err), 32'(v.exp_err));
            if (!v.wr && !v.exp_err) begin
                check({tag, " hrdata"}, rd, v.exp_rd);
            end
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] sz, input logic [19:0] a,
                                input logic [31:0] wd, input logic [3:0] wt,
                                input logic [31:0] rd, input logic er, input int cy);
        vec_t v;
        v.wr = wr; v.size = sz; v.addr = a; v.wdata = wd; v.wt = wt;
        v.exp_rd = rd; v.exp_err = er; v.exp_cyc = cy;
        return v;
    endfunction

    logic [31:0] bd [4];
    logic [1:0]  bt [6];
    logic [19:0] ba [6];
    logic [31:0] bx [5];
    int          beat;
    int          dcyc;
    logic        rdy;

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        //            wr    size       addr      wdata         wt    exp_rd        err  cyc
        vecs[0]  = mk(1'b1, HSIZE_B32, 20'h00000, 32'h01020304, 4'd0, 32'h0,        1'b0, 1);
        vecs[1]  = mk(1'b1, HSIZE_B32, 20'h00010, 32'hDEADBEEF, 4'd0, 32'h0,        1'b0, 1);
        vecs[2]  = mk(1'b0, HSIZE_B32, 20'h00010, 32'h0,        4'd0, 32'hDEADBEEF, 1'b0, 1);
        vecs[3]  = mk(1'b1, HSIZE_B8,  20'h00013, 32'hAA000000, 4'd0, 32'h0,        1'b0, 1);
        vecs[4]  = mk(1'b1, HSIZE_B16, 20'h00010, 32'h00005566, 4'd0, 32'h0,        1'b0, 1);
        vecs[5]  = mk(1'b0, HSIZE_B32, 20'h00010, 32'h0,        4'd0, 32'hAAAD5566, 1'b0, 1);
        vecs[6]  = mk(1'b0, HSIZE_B32, 20'h00010, 32'h0,        4'd3, 32'hAAAD5566, 1'b0, 4);
        vecs[7]  = mk(1'b0, HSIZE_B32, 20'hF0000, 32'h0,        4'd0, 32'h0,        1'b1, 2);
        vecs[8]  = mk(1'b1, HSIZE_B32, 20'h00002, 32'hFFFFFFFF, 4'd0, 32'h0,        1'b1, 2);
        vecs[9]  = mk(1'b1, HSIZE_B32, 20'h01000, 32'hFFFFFFFF, 4'd7, 32'h0,        1'b1, 2);
        vecs[10] = mk(1'b1, HSIZE_B64, 20'h00000, 32'hFFFFFFFF, 4'd0, 32'h0,        1'b1, 2);
        vecs[11] = mk(1'b0, HSIZE_B32, 20'h00000, 32'h0,        4'd0, 32'h01020304, 1'b0, 1);
        vecs[12] = mk(1'b1, HSIZE_B8,  20'h00011, 32'h00007700, 4'd2, 32'h0,        1'b0, 3);
        vecs[13] = mk(1'b0, HSIZE_B16, 20'h00012, 32'h0,        4'd0, 32'hAAAD7766, 1'b0, 1);
        vecs[14] = mk(1'b0, HSIZE_B32, 20'h00010, 32'h0,        4'd15, 32'hAAAD7766, 1'b0, 16);
        vecs[15] = mk(1'b1, HSIZE_B32, 20'h00FFC, 32'h00000000, 4'd1, 32'h0,        1'b0, 2);
        vecs[16] = mk(1'b1, HSIZE_B16, 20'h00FFE, 32'hBEEF0000, 4'd0, 32'h0,        1'b0, 1);
        vecs[17] = mk(1'b0, HSIZE_B32, 20'h00FFC, 32'h0,        4'd0, 32'hBEEF0000, 1'b0, 1);
        vecs[18] = mk(1'b1, HSIZE_B16, 20'h00011, 32'h12345678, 4'd0, 32'h0,        1'b1, 2);
        vecs[19] = mk(1'b0, HSIZE_B32, 20'h00010, 32'h0,        4'd0, 32'hAAAD7766, 1'b0, 1);

        bd[0] = 32'h40404040; bd[1] = 32'h44444444; bd[2] = 32'h48484848; bd[3] = 32'h4C4C4C4C;

        // Reset values.
        HRESETn = 1'b0;
        bus_idle();
        HWDATA = '0;
        #12;
        check("reset hreadyout", 32'(HREADYOUT), 32'd1);
        check("reset hresp", 32'(HRESP), 32'd0);
        check("reset hrdata", HRDATA, 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Table of single transfers.
        for (int i = 0; i < NV; i++) begin
            do_xfer(vecs[i], $sformatf("v%0d", i));
        end

        // Pipelined write then read of the same word at wait 0.
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 20'h00020; HWRITE = 1'b1;
        HSIZE = HSIZE_B32; wait_i = 4'd0;
        @(posedge HCLK); #1;
        HWDATA = 32'h11223344;
        HTRANS = HTRANS_NONSEQ; HADDR = 20'h00020; HWRITE = 1'b0;
        @(negedge HCLK);
        check("hazard wr ready", 32'(HREADYOUT), 32'd1);
        @(posedge HCLK); #1;
        bus_idle();
        @(negedge HCLK);
        check("hazard rd ready", 32'(HREADYOUT), 32'd1);
        check("hazard rd hresp", 32'(HRESP), 32'd0);
        check("hazard rd data", HRDATA, 32'h11223344);
        @(posedge HCLK); #1;

        // INCR4 write burst with 3 wait states per beat.
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 20'h00040; HWRITE = 1'b1;
        HSIZE = HSIZE_B32; HBURST = HBURST_INCR4; wait_i = 4'd3;
        @(posedge HCLK); #1;
        beat = 0;
        dcyc = 0;
        HWDATA = bd[0];
        HTRANS = HTRANS_SEQ; HADDR = 20'h00044;
        for (int k = 0; k < 100 && beat < 4; k++) begin
            @(negedge HCLK);
            dcyc++;
            rdy = HREADYOUT;
            @(posedge HCLK); #1;
            if (rdy) begin
                beat++;
                if (beat < 4) HWDATA = bd[beat];
                if (beat + 1 < 4) begin
                    HTRANS = HTRANS_SEQ;
                    HADDR  = 20'(32'h40 + 32'(4 * (beat + 1)));
                end else begin
                    bus_idle();
                end
            end
        end
        check("incr4 beats", 32'(beat), 32'd4);
        check("incr4 data cycles", 32'(dcyc), 32'd16);
        do_xfer(mk(1'b0, HSIZE_B32, 20'h00048, 32'h0, 4'd0, 32'h48484848, 1'b0, 1), "incr4 rb");

        // INCR4 read burst with a BUSY cycle after the first beat.
        do_xfer(mk(1'b1, HSIZE_B32, 20'h00050, 32'hA0A0A0A0, 4'd0, 32'h0, 1'b0, 1), "busy pw0");
        do_xfer(mk(1'b1, HSIZE_B32, 20'h00054, 32'hB0B0B0B0, 4'd0, 32'h0, 1'b0, 1), "busy pw1");
        do_xfer(mk(1'b1, HSIZE_B32, 20'h00058, 32'hC0C0C0C0, 4'd0, 32'h0, 1'b0, 1), "busy pw2");
        do_xfer(mk(1'b1, HSIZE_B32, 20'h0005C, 32'hD0D0D0D0, 4'd0, 32'h0, 1'b0, 1), "busy pw3");
        bt[0] = HTRANS_NONSEQ; ba[0] = 20'h00050;
        bt[1] = HTRANS_BUSY;   ba[1] = 20'h00054;
        bt[2] = HTRANS_SEQ;    ba[2] = 20'h00054;
        bt[3] = HTRANS_SEQ;    ba[3] = 20'h00058;
        bt[4] = HTRANS_SEQ;    ba[4] = 20'h0005C;
        bt[5] = HTRANS_IDLE;   ba[5] = 20'h00000;
        bx[0] = 32'hA0A0A0A0; bx[1] = 32'hA0A0A0A0; bx[2] = 32'hB0B0B0B0;
        bx[3] = 32'hC0C0C0C0; bx[4] = 32'hD0D0D0D0;
        for (int i = 0; i < 6; i++) begin
            HSEL   = (bt[i] != HTRANS_IDLE);
            HTRANS = bt[i];
            HADDR  = ba[i];
            HWRITE = 1'b0;
            HSIZE  = HSIZE_B32;
            HBURST = HBURST_INCR4;
            wait_i = 4'd0;
            @(negedge HCLK);
            if (i > 0) begin
                check($sformatf("busy c%0d ready", i), 32'(HREADYOUT), 32'd1);
                check($sformatf("busy c%0d hresp", i), 32'(HRESP), 32'd0);
                check($sformatf("busy c%0d data", i), HRDATA, bx[i-1]);
            end
            @(posedge HCLK); #1;
        end
        bus_idle();

        // Asynchronous reset during wait states drops the pending write.
        do_xfer(mk(1'b1, HSIZE_B32, 20'h00030, 32'h12345678, 4'd0, 32'h0, 1'b0, 1), "rst pw");
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 20'h00030; HWRITE = 1'b1;
        HSIZE = HSIZE_B32; wait_i = 4'd5;
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = 32'hCAFEF00D;
        @(negedge HCLK);
        check("rst pre ready", 32'(HREADYOUT), 32'd0);
        #1;
        HRESETn = 1'b0;
        #1;
        check("rst async ready", 32'(HREADYOUT), 32'd1);
        check("rst async hresp", 32'(HRESP), 32'd0);
        check("rst async hrdata", HRDATA, 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        do_xfer(mk(1'b0, HSIZE_B32, 20'h00030, 32'h0, 4'd0, 32'h12345678, 1'b0, 1), "rst rb");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
